// File: rtl/ryuki_datatypes.sv
// Shared processor datatypes: the completed trace element produced by wb_tracker
// and the constants that describe how it is framed on the trace link.
package ryuki_datatypes;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        rd_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic [1:0]  mem_op;
        logic        pass_through;
    } trace_output;

    localparam int         TRACE_W     = $bits(trace_output);
    localparam int         TRACE_WORDS = (TRACE_W + 31) / 32;
    localparam logic [7:0] TRACE_SYNC  = 8'hA5;

endpackage

// File: rtl/trace_serializer_pkg.sv
// Serializer-local types and the word formatters shared by the framing FSM.
package trace_serializer_pkg;
    import ryuki_datatypes::*;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } ser_state_e;

    localparam int IDX_W = (TRACE_WORDS > 1) ? $clog2(TRACE_WORDS) : 1;
    localparam int PAD_W = TRACE_WORDS * 32;

    function automatic logic [31:0] make_header(input logic [7:0] seq, input logic drop);
        return {TRACE_SYNC, seq, drop, 7'd0, 8'(TRACE_WORDS)};
    endfunction

    // Zero-extend the element to whole words, then pick word k (LSW first).
    function automatic logic [31:0] payload_word(input trace_output t, input logic [IDX_W-1:0] k);
        logic [PAD_W-1:0] padded;
        padded = PAD_W'(t);
        return padded[32*int'(k) +: 32];
    endfunction

endpackage

// File: rtl/trace_serializer_fifo.sv
// First-word-fall-through element FIFO; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module trace_serializer_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/trace_serializer.sv
// Buffers completed trace elements and streams each one as a sync header
// followed by TRACE_WORDS payload words over a valid/ready word link.
module trace_serializer
    import ryuki_datatypes::*;
    import trace_serializer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  trace_output                   trace_i,
    input  logic                          trace_ready_i,
    output logic [31:0]                   tx_data_o,
    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
    output logic [15:0]                   drop_count_o
);
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("trace_serializer: FIFO_DEPTH must be a power of two >= 2");
    end

    ser_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    trace_output       frame_q, frame_d;
    logic [31:0]       tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        seq_q, seq_d;
    logic              drop_flag_q, drop_flag_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_count_q, drop_count_d;

    logic              pop, push, drop, hdr_xfer;
    logic              fifo_full, fifo_empty;
    logic [TRACE_W-1:0] fifo_head;

    assign push = trace_ready_i && (!fifo_full || pop);
    assign drop = trace_ready_i && !push;

    trace_serializer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TRACE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (trace_i),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    // Framing FSM; the header is formatted when the element is popped so the
    // word stays stable for as long as the link stalls.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        pop        = 1'b0;
        hdr_xfer   = 1'b0;
        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    frame_d    = fifo_head;
                    idx_d      = '0;
                    tx_data_d  = make_header(seq_q, drop_flag_q);
                    tx_valid_d = 1'b1;
                    state_d    = HEADER;
                end
            end
            HEADER: begin
                if (tx_ready_i) begin
                    hdr_xfer  = 1'b1;
                    idx_d     = '0;
                    tx_data_d = payload_word(frame_q, '0);
                    state_d   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (tx_ready_i) begin
                    if (idx_q == IDX_W'(TRACE_WORDS - 1)) begin
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            frame_d    = fifo_head;
                            idx_d      = '0;
                            tx_data_d  = make_header(seq_q, drop_flag_q);
                            tx_valid_d = 1'b1;
                            state_d    = HEADER;
                        end else begin
                            tx_data_d  = '0;
                            tx_valid_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        tx_data_d = payload_word(frame_q, idx_q + 1'b1);
                    end
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // A drop on the header-transfer edge wins over the clear.
    always_comb begin
        seq_d        = hdr_xfer ? seq_q + 8'd1 : seq_q;
        drop_flag_d  = hdr_xfer ? 1'b0 : drop_flag_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            drop_flag_d = 1'b1;
            overflow_d  = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            frame_q      <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            seq_q        <= '0;
            drop_flag_q  <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            seq_q        <= seq_d;
            drop_flag_q  <= drop_flag_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_valid_o   = tx_valid_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_count_q;

endmodule
